// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder, the cell reused on every cycle of the serial add.
module fa_cell (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, one operand bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t state, next_state;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] ss;
  logic [WIDTH-1:0] ss_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_co;
  logic             last_bit;

  fa_cell u_cell (
    .s  (cell_s),
    .co (cell_co),
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c)
  );

  // ss keeps only the WIDTH-1 bits already produced; the current cell output completes the word.
  assign ss_next  = {cell_s, ss};
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      ss  <= '0;
      c   <= 1'b0;
      cnt <= '0;
      sum <= '0;
      co  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            c   <= ci;
            cnt <= '0;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          ss <= ss_next[WIDTH-1:1];
          c  <= cell_co;
          // Hold the counter on the final bit so it never wraps.
          if (last_bit) begin
            sum <= ss_next;
            co  <= cell_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
